// File: rtl/xbus_pkg.sv
// Shared types and constants for the xbus peripheral fabric: FSM states, fault kinds
// and the layout of the fault status word.
package xbus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StResp  = 2'd2,
    StDrain = 2'd3
  } state_e;

  localparam logic [1:0] FK_NONE     = 2'd0;
  localparam logic [1:0] FK_TIMEOUT  = 2'd1;
  localparam logic [1:0] FK_UNMAPPED = 2'd2;

  localparam int unsigned STAT_COUNT_LSB = 24;
  localparam int unsigned STAT_KIND_LSB  = 16;
  localparam int unsigned STAT_ADDR_LSB  = 0;

  function automatic logic [31:0] status_word(input logic [7:0]  count,
                                              input logic [1:0]  kind,
                                              input logic [15:0] addr);
    logic [31:0] word;
    word = '0;
    word[STAT_COUNT_LSB +: 8] = count;
    word[STAT_KIND_LSB +: 2]  = kind;
    word[STAT_ADDR_LSB +: 16] = addr;
    return word;
  endfunction

endpackage

// File: rtl/xbus_decode.sv
// Address decoder: maps the top address bits to a one-hot slot hit, a status-register
// hit, or a miss. Lowest slot index wins on duplicate bases.
module xbus_decode
  import xbus_pkg::*;
#(
  parameter int unsigned              NSLOTS    = 4,
  parameter int unsigned              AWIDTH    = 8,
  parameter logic [NSLOTS*AWIDTH-1:0] SLOT_BASE = {8'h70, 8'h60, 8'h50, 8'h40},
  parameter logic [AWIDTH-1:0]        STAT_ADDR = 8'h7F
) (
  input  logic [AWIDTH-1:0] tag,
  output logic [NSLOTS-1:0] slot_hit,
  output logic              stat_hit,
  output logic              miss
);

  logic found;

  always_comb begin
    slot_hit = '0;
    found    = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (!found && tag == SLOT_BASE[k*AWIDTH +: AWIDTH]) begin
        slot_hit[k] = 1'b1;
        found       = 1'b1;
      end
    end
    stat_hit = !found && (tag == STAT_ADDR);
    miss     = !found && !stat_hit;
  end

endmodule

// File: rtl/xbus_fabric.sv
// Wishbone peripheral fabric: decodes CPU accesses to one of NSLOTS slaves, muxes the
// response, and reports unmapped or timed-out accesses through a status register and irq.
module xbus_fabric
  import xbus_pkg::*;
#(
  parameter int unsigned              NSLOTS    = 4,
  parameter int unsigned              AWIDTH    = 8,
  parameter logic [NSLOTS*AWIDTH-1:0] SLOT_BASE = {8'h70, 8'h60, 8'h50, 8'h40},
  parameter logic [AWIDTH-1:0]        STAT_ADDR = 8'h7F,
  parameter int unsigned              TIMEOUT   = 16,
  parameter logic [31:0]              ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [31:0]          wb_dbus_adr,
  input  logic [31:0]          wb_dbus_dat,
  input  logic                 wb_dbus_we,
  input  logic                 wb_dbus_cyc,
  output logic [31:0]          wb_xbus_rdt,
  output logic                 wb_xbus_ack,
  output logic [NSLOTS-1:0]    s_cyc,
  input  logic [NSLOTS*32-1:0] s_rdt,
  input  logic [NSLOTS-1:0]    s_ack,
  output logic                 bus_irq
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state;
  logic [7:0]  timer;
  logic [7:0]  fault_count, fault_count_d;
  logic [1:0]  fault_kind, fault_kind_new;
  logic [15:0] fault_addr;

  logic [NSLOTS-1:0] slot_hit;
  logic              stat_hit, miss;
  logic              sel_ack, timeout_hit, fault_new, stat_clear;
  logic [31:0]       sel_rdt;

  // Slaves see the write data directly; only the address top bits reach the decoder.
  logic unused_ok;
  assign unused_ok = ^wb_dbus_dat ^ (^wb_dbus_adr);

  xbus_decode #(
    .NSLOTS   (NSLOTS),
    .AWIDTH   (AWIDTH),
    .SLOT_BASE(SLOT_BASE),
    .STAT_ADDR(STAT_ADDR)
  ) u_decode (
    .tag     (wb_dbus_adr[31 -: AWIDTH]),
    .slot_hit(slot_hit),
    .stat_hit(stat_hit),
    .miss    (miss)
  );

  always_comb begin
    sel_rdt = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (s_cyc[k]) sel_rdt |= s_rdt[k*32 +: 32];
    end
  end

  assign sel_ack     = |(s_ack & s_cyc);
  assign timeout_hit = (timer == TIMER_LAST);
  assign stat_clear  = (state == StIdle) && wb_dbus_cyc && stat_hit && wb_dbus_we;

  always_comb begin
    fault_new      = 1'b0;
    fault_kind_new = FK_NONE;
    if (state == StIdle && wb_dbus_cyc && miss) begin
      fault_new      = 1'b1;
      fault_kind_new = FK_UNMAPPED;
    end else if (state == StWait && wb_dbus_cyc && !sel_ack && timeout_hit) begin
      fault_new      = 1'b1;
      fault_kind_new = FK_TIMEOUT;
    end
  end

  // Clear has priority over a simultaneous fault; count saturates at 255.
  always_comb begin
    fault_count_d = fault_count;
    if (stat_clear) begin
      fault_count_d = '0;
    end else if (fault_new && fault_count != 8'hFF) begin
      fault_count_d = fault_count + 8'd1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= StIdle;
      timer       <= '0;
      s_cyc       <= '0;
      wb_xbus_ack <= 1'b0;
      wb_xbus_rdt <= '0;
      fault_count <= '0;
      fault_kind  <= FK_NONE;
      fault_addr  <= '0;
      bus_irq     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (wb_dbus_cyc) begin
            if (|slot_hit) begin
              s_cyc <= slot_hit;
              timer <= '0;
              state <= StWait;
            end else if (stat_hit) begin
              wb_xbus_ack <= 1'b1;
              wb_xbus_rdt <= wb_dbus_we ? 32'h0 :
                             status_word(fault_count, fault_kind, fault_addr);
              state       <= StResp;
            end else begin
              wb_xbus_ack <= 1'b1;
              wb_xbus_rdt <= ERR_DATA;
              state       <= StResp;
            end
          end
        end
        StWait: begin
          if (!wb_dbus_cyc) begin
            s_cyc <= '0;
            state <= StIdle;
          end else if (sel_ack) begin
            s_cyc       <= '0;
            wb_xbus_ack <= 1'b1;
            wb_xbus_rdt <= sel_rdt;
            state       <= StResp;
          end else if (timeout_hit) begin
            s_cyc       <= '0;
            wb_xbus_ack <= 1'b1;
            wb_xbus_rdt <= ERR_DATA;
            state       <= StResp;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        StResp: begin
          wb_xbus_ack <= 1'b0;
          wb_xbus_rdt <= '0;
          state       <= StDrain;
        end
        StDrain: begin
          if (!wb_dbus_cyc) state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      fault_count <= fault_count_d;
      bus_irq     <= (fault_count_d != 8'h00);
      if (stat_clear) begin
        fault_kind <= FK_NONE;
        fault_addr <= '0;
      end else if (fault_new) begin
        fault_kind <= fault_kind_new;
        fault_addr <= wb_dbus_adr[15:0];
      end
    end
  end

endmodule

// File: tb/tb_xbus_fabric.sv
// Directed, table-driven bench for xbus_fabric with hand-written abort, reset and
// saturation sequences.
module tb_xbus_fabric;

  localparam int NS = 4;

  logic             clk;
  logic             rst_n;
  logic [31:0]      wb_dbus_adr;
  logic [31:0]      wb_dbus_dat;
  logic             wb_dbus_we;
  logic             wb_dbus_cyc;
  logic [31:0]      wb_xbus_rdt;
  logic             wb_xbus_ack;
  logic [NS-1:0]    s_cyc;
  logic [NS*32-1:0] s_rdt;
  logic [NS-1:0]    s_ack;
  logic             bus_irq;

  int n_checks = 0;
  int n_fail   = 0;

  xbus_fabric dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .wb_dbus_adr(wb_dbus_adr),
    .wb_dbus_dat(wb_dbus_dat),
    .wb_dbus_we (wb_dbus_we),
    .wb_dbus_cyc(wb_dbus_cyc),
    .wb_xbus_rdt(wb_xbus_rdt),
    .wb_xbus_ack(wb_xbus_ack),
    .s_cyc      (s_cyc),
    .s_rdt      (s_rdt),
    .s_ack      (s_ack),
    .bus_irq    (bus_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access; cycle 0 is the first cycle cyc is high. The slave model acks
  // 'delay' cycles after s_cyc first appears (delay < 0: never).
  task automatic run_txn(input logic [31:0] adr, input logic we, input int slot,
                         input int delay, input logic [31:0] srdt, input logic noise,
                         output int ack_n, output logic [31:0] rdt,
                         output logic [NS-1:0] scyc, output logic irq);
    int first;
    first = -1;
    ack_n = -1;
    rdt   = '0;
    scyc  = '0;
    irq   = 1'b0;
    @(posedge clk); #1;
    wb_dbus_adr = adr;
    wb_dbus_we  = we;
    wb_dbus_cyc = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (wb_xbus_ack) begin
        ack_n = n;
        rdt   = wb_xbus_rdt;
        irq   = bus_irq;
        break;
      end
      if (s_cyc != '0 && first < 0) begin
        first = n;
        scyc  = s_cyc;
      end
      s_ack = '0;
      s_rdt = {NS{32'hBAD0_0000}};
      if (noise && s_cyc != '0) s_ack = ~s_cyc;
      if (slot >= 0 && delay >= 0 && first >= 0 && s_cyc[slot] && n - first == delay) begin
        s_ack[slot]          = 1'b1;
        s_rdt[slot*32 +: 32] = srdt;
      end
      @(posedge clk); #1;
    end
    s_ack = '0;
    @(posedge clk); #1;
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    @(negedge clk);
    check("ack_pulse_end", {31'b0, wb_xbus_ack}, 32'h0);
    check("rdt_zero_after_ack", wb_xbus_rdt, 32'h0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          slot;
    int          delay;
    logic [31:0] srdt;
    logic        noise;
    int          exp_ack;
    logic [31:0] exp_rdt;
    logic [3:0]  exp_scyc;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          ack_n;
    logic [31:0] rdt;
    logic [NS-1:0] scyc;
    logic        irq;

    // Sequential scenario: state (fault counters) carries between rows.
    vecs[0]  = '{32'h5000_0004, 1'b0, 1, 2,  32'h1234_5678, 1'b1, 4,  32'h1234_5678, 4'b0010, 1'b0};
    vecs[1]  = '{32'h7F00_0000, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'h0000_0000, 4'b0000, 1'b0};
    vecs[2]  = '{32'h6000_0000, 1'b0, 2, -1, 32'h0,         1'b0, 17, 32'hDEAD_BEEF, 4'b0100, 1'b1};
    vecs[3]  = '{32'h7F00_0000, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'h0101_0000, 4'b0000, 1'b1};
    vecs[4]  = '{32'h9000_00AC, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'hDEAD_BEEF, 4'b0000, 1'b1};
    vecs[5]  = '{32'h7F00_0000, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'h0202_00AC, 4'b0000, 1'b1};
    vecs[6]  = '{32'h7000_1234, 1'b0, 3, 0,  32'hA5A5_0001, 1'b0, 2,  32'hA5A5_0001, 4'b1000, 1'b1};
    vecs[7]  = '{32'h4000_0010, 1'b0, 0, 15, 32'hCAFE_F00D, 1'b0, 17, 32'hCAFE_F00D, 4'b0001, 1'b1};
    vecs[8]  = '{32'h0000_BEEF, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'hDEAD_BEEF, 4'b0000, 1'b1};
    vecs[9]  = '{32'h7F00_0000, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'h0302_BEEF, 4'b0000, 1'b1};
    vecs[10] = '{32'h7F00_0000, 1'b1, -1, -1, 32'h0,        1'b0, 1,  32'h0000_0000, 4'b0000, 1'b0};
    vecs[11] = '{32'h7F00_0000, 1'b0, -1, -1, 32'h0,        1'b0, 1,  32'h0000_0000, 4'b0000, 1'b0};

    rst_n       = 1'b0;
    wb_dbus_adr = '0;
    wb_dbus_dat = 32'h5555_AAAA;
    wb_dbus_we  = 1'b0;
    wb_dbus_cyc = 1'b0;
    s_rdt       = '0;
    s_ack       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_cyc", {28'b0, s_cyc}, 32'h0);
    check("reset_ack", {31'b0, wb_xbus_ack}, 32'h0);
    check("reset_rdt", wb_xbus_rdt, 32'h0);
    check("reset_irq", {31'b0, bus_irq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].adr, vecs[i].we, vecs[i].slot, vecs[i].delay, vecs[i].srdt,
              vecs[i].noise, ack_n, rdt, scyc, irq);
      check($sformatf("vec%0d_ack_cycle", i), 32'(ack_n), 32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_rdt", i), rdt, vecs[i].exp_rdt);
      check($sformatf("vec%0d_s_cyc", i), {28'b0, scyc}, {28'b0, vecs[i].exp_scyc});
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Abort: cyc drops in cycle 3 of WAIT; no ack, no fault.
    @(posedge clk); #1;
    wb_dbus_adr = 32'h5000_0000;
    wb_dbus_cyc = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_s_cyc_set", {28'b0, s_cyc}, 32'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_dbus_cyc = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("abort_no_ack", {31'b0, wb_xbus_ack}, 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("abort_s_cyc_clear", {28'b0, s_cyc}, 32'h0);
    check("abort_no_irq", {31'b0, bus_irq}, 32'h0);
    run_txn(32'h7F00_0000, 1'b0, -1, -1, 32'h0, 1'b0, ack_n, rdt, scyc, irq);
    check("abort_status", rdt, 32'h0);

    // Asynchronous reset in WAIT, with a fault pending so irq is high.
    run_txn(32'hA000_0001, 1'b0, -1, -1, 32'h0, 1'b0, ack_n, rdt, scyc, irq);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    wb_dbus_adr = 32'h6000_0000;
    wb_dbus_cyc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_s_cyc", {28'b0, s_cyc}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_s_cyc", {28'b0, s_cyc}, 32'h0);
    check("async_reset_ack", {31'b0, wb_xbus_ack}, 32'h0);
    check("async_reset_rdt", wb_xbus_rdt, 32'h0);
    check("async_reset_irq", {31'b0, bus_irq}, 32'h0);
    wb_dbus_cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(32'h7F00_0000, 1'b0, -1, -1, 32'h0, 1'b0, ack_n, rdt, scyc, irq);
    check("post_reset_ack_cycle", 32'(ack_n), 32'd1);
    check("post_reset_status", rdt, 32'h0);

    // Saturation: 300 unmapped accesses.
    for (int i = 0; i < 300; i++) begin
      run_txn(32'h9000_0000 | 32'(i), 1'b0, -1, -1, 32'h0, 1'b0, ack_n, rdt, scyc, irq);
    end
    run_txn(32'h7F00_0000, 1'b0, -1, -1, 32'h0, 1'b0, ack_n, rdt, scyc, irq);
    check("saturated_status", rdt, 32'hFF02_012B);
    check("saturated_irq", {31'b0, irq}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
